// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT  = 32'h8000_0000;

  // Bit 2 of funct3 separates the divide family from the multiply family
  function automatic logic is_div_op(input md_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// Multiply: acc is the upper product half; cur_bit is the multiplier LSB.
//   The 33-bit sum is shifted right: acc_next gets its upper 32 bits and
//   q_bit is the bit that drops into the top of the lower product half.
// Divide: acc is the partial remainder; cur_bit is the next dividend bit.
//   q_bit is the new quotient bit, acc_next the restored/updated remainder.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] opnd,
  input  logic            cur_bit,
  output logic [XLEN-1:0] acc_next,
  output logic            q_bit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] sub;
  logic          fits;
  logic          unused_sub_msb;

  // Remainder never exceeds the divisor, so the difference MSB is always 0 when kept
  assign unused_sub_msb = sub[XLEN];

  // Single multiply or divide iteration
  always_comb begin
    sum      = cur_bit ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    shifted  = {acc, cur_bit};
    sub      = shifted - {1'b0, opnd};
    fits     = (shifted >= {1'b0, opnd});
    acc_next = sum[XLEN:1];
    q_bit    = sum[0];
    if (div_mode) begin
      q_bit    = fits;
      acc_next = fits ? sub[XLEN-1:0] : shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit attached to Execute. Works on operand
// magnitudes for 32 cycles while holding the front of the pipe with a stall
// request, then presents the sign-corrected result for one DONE cycle (longer
// if Execute is held by another hazard). Divide-by-zero and signed overflow
// skip the iteration and go straight to DONE with the architectural result.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            stall_e_i,
  input  logic            flush_e_i,
  output logic            stall_req_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  mdu_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  md_op_t          op_q;
  logic            sign_a, sign_b, special;
  logic [XLEN-1:0] mag_b, hi, lo, spec_res;

  md_op_t          op_in;
  logic            start_go;
  logic            in_sa, in_sb, in_b_zero, in_ovf, in_special;
  logic [XLEN-1:0] in_mag_a, in_mag_b, in_spec_res;

  logic            div_mode, step_bit, step_q;
  logic [XLEN-1:0] step_acc;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  assign op_in    = md_op_t'(md_op_i);
  assign start_go = start_i & ~flush_e_i;

  // Decode the incoming op: signedness, magnitudes and special-case results
  always_comb begin
    in_sa       = src_a_i[XLEN-1] & (op_in == MD_MULH || op_in == MD_MULHSU ||
                                     op_in == MD_DIV  || op_in == MD_REM);
    in_sb       = src_b_i[XLEN-1] & (op_in == MD_MULH || op_in == MD_DIV ||
                                     op_in == MD_REM);
    in_mag_a    = cneg(src_a_i, in_sa);
    in_mag_b    = cneg(src_b_i, in_sb);
    in_b_zero   = (src_b_i == '0);
    in_ovf      = (op_in == MD_DIV || op_in == MD_REM) &&
                  (src_a_i == OVF_QUOT) && (src_b_i == '1);
    in_special  = is_div_op(op_in) & (in_b_zero | in_ovf);
    in_spec_res = md_op_i[1] ? (in_b_zero ? src_a_i : '0)
                             : (in_b_zero ? DIV0_QUOT : OVF_QUOT);
  end

  assign div_mode = is_div_op(op_q);
  assign step_bit = div_mode ? lo[XLEN-1] : lo[0];

  mdu_step #(.XLEN(XLEN)) u_step (
    .div_mode (div_mode),
    .acc      (hi),
    .opnd     (mag_b),
    .cur_bit  (step_bit),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state logic; a flush abandons any op in flight
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_go) state_nxt = in_special ? DONE : CALC;
      CALC: begin
        if (flush_e_i)       state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = DONE;
      end
      DONE: if (flush_e_i || !stall_e_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on start, then one iteration per CALC cycle
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt      <= '0;
      op_q     <= MD_MUL;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      special  <= 1'b0;
      mag_b    <= '0;
      hi       <= '0;
      lo       <= '0;
      spec_res <= '0;
    end else if (state == IDLE && start_go) begin
      cnt      <= CNT_W'(XLEN - 1);
      op_q     <= op_in;
      sign_a   <= in_sa;
      sign_b   <= in_sb;
      special  <= in_special;
      mag_b    <= in_mag_b;
      hi       <= '0;
      lo       <= in_mag_a;
      spec_res <= in_spec_res;
    end else if (state == CALC && !flush_e_i) begin
      cnt <= cnt - 1'b1;
      hi  <= step_acc;
      lo  <= div_mode ? {lo[XLEN-2:0], step_q} : {step_q, lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection from the finished magnitudes
  always_comb begin
    prod_fix = cneg_wide({hi, lo}, sign_a ^ sign_b);
    quot_fix = cneg(lo, sign_a ^ sign_b);
    rem_fix  = cneg(hi, sign_a);
    case (op_q)
      MD_MUL:                       final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quot_fix;
      default:                      final_res = rem_fix;
    endcase
    if (special) final_res = spec_res;
  end

  // FSM outputs; the result is only ever driven while valid
  always_comb begin
    stall_req_o    = ((state == IDLE) && start_go) || (state == CALC);
    busy_o         = (state != IDLE);
    result_valid_o = (state == DONE) && !flush_e_i;
    result_o       = result_valid_o ? final_res : '0;
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed RV32M corner cases plus randomized ops,
// each compared cycle by cycle against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  md_op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_e_i, flush_e_i;
  logic        stall_req_o, busy_o, result_valid_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  mdu_sequencer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .start_i        (start_i),
    .md_op_i        (md_op_i),
    .src_a_i        (src_a_i),
    .src_b_i        (src_b_i),
    .stall_e_i      (stall_e_i),
    .flush_e_i      (flush_e_i),
    .stall_req_o    (stall_req_o),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: architectural RV32M result using 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic e_stall, input logic e_busy,
                             input logic e_valid, input logic [31:0] e_res);
    chk({tag, " stall_req"}, {31'b0, stall_req_o}, {31'b0, e_stall});
    chk({tag, " busy"}, {31'b0, busy_o}, {31'b0, e_busy});
    chk({tag, " valid"}, {31'b0, result_valid_o}, {31'b0, e_valid});
    if (e_valid) chk({tag, " result"}, result_o, e_res);
  endtask

  // One op held in E from start until it leaves DONE; optional CALC flush
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int nstall, input int flush_at, input bit scramble);
    logic [31:0] exp;
    bit special;
    exp = model(op, a, b);
    special = op[2] && (b == 32'd0 || ((op == 3'd4 || op == 3'd6) &&
              a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(posedge clk_i); #1;
    start_i = 1'b1; md_op_i = op; src_a_i = a; src_b_i = b;
    flush_e_i = 1'b0; stall_e_i = 1'b0;
    @(negedge clk_i);
    check_cycle("start", 1'b1, 1'b0, 1'b0, 32'd0);
    if (!special) begin
      for (int k = 1; k <= 32; k++) begin
        @(posedge clk_i); #1;
        if (scramble) begin src_a_i = $urandom; src_b_i = $urandom; end
        stall_e_i = 1'($urandom_range(0, 1));
        flush_e_i = (k == flush_at);
        @(negedge clk_i);
        check_cycle("calc", 1'b1, 1'b1, 1'b0, 32'd0);
        if (k == flush_at) begin
          @(posedge clk_i); #1;
          start_i = 1'b0; flush_e_i = 1'b0; stall_e_i = 1'b0;
          @(negedge clk_i);
          check_cycle("flushed", 1'b0, 1'b0, 1'b0, 32'd0);
          return;
        end
      end
    end
    for (int k = 0; k <= nstall; k++) begin
      @(posedge clk_i); #1;
      flush_e_i = 1'b0;
      stall_e_i = (k < nstall);
      @(negedge clk_i);
      check_cycle("done", 1'b0, 1'b1, 1'b1, exp);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; stall_e_i = 1'b0;
    @(negedge clk_i);
    check_cycle("idle", 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, " stall_req"}, {31'b0, stall_req_o}, 32'd0);
    chk({tag, " busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, " valid"}, {31'b0, result_valid_o}, 32'd0);
    chk({tag, " result"}, result_o, 32'd0);
  endtask

  initial begin
    reset_i = 1'b0; start_i = 1'b0; md_op_i = 3'd0;
    src_a_i = 32'd0; src_b_i = 32'd0; stall_e_i = 1'b0; flush_e_i = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); reset_i = 1'b1;

    // Model pinned to hand-computed values
    chk("model MUL", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model DIV ovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("model REM ovf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    chk("model DIVU0", model(3'd5, 32'h1234_5678, 32'd0), 32'hFFFF_FFFF);
    chk("model REMU0", model(3'd7, 32'd5, 32'd0), 32'd5);
    chk("model DIV neg", model(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model REM neg", model(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model MULH", model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd0);
    chk("model MULHSU", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model MULHU", model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model MUL -1", model(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'd1);

    // Directed corner cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 1'b1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(3'd5, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 0, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1);
    for (int op = 0; op < 4; op++)
      run_op(3'(op), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1);
    run_op(3'd0, 32'd9, 32'd9, 0, 10, 1'b0);
    run_op(3'd0, 32'd3, 32'd4, 0, 0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 3, 0, 1'b1);
    run_op(3'd5, 32'd0, 32'd0, 3, 0, 1'b0);

    // Start coinciding with a flush must not launch an op
    @(posedge clk_i); #1;
    start_i = 1'b1; flush_e_i = 1'b1; md_op_i = 3'd0; src_a_i = 32'd2; src_b_i = 32'd2;
    @(negedge clk_i);
    check_cycle("start+flush", 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_e_i = 1'b0;
    @(negedge clk_i);
    check_cycle("after start+flush", 1'b0, 1'b0, 1'b0, 32'd0);

    // Asynchronous reset in the middle of CALC
    @(posedge clk_i); #1;
    start_i = 1'b1; md_op_i = 3'd4; src_a_i = 32'd1000; src_b_i = 32'd7;
    repeat (10) @(posedge clk_i);
    #2;
    start_i = 1'b0;
    reset_i = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk_i); reset_i = 1'b1;
    @(negedge clk_i);
    check_cycle("post reset", 1'b0, 1'b0, 1'b0, 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 1, 0, 1'b0);

    // Randomized ops with random DONE stalls and occasional CALC flushes
    for (int n = 0; n < 120; n++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      int fl;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 32)) : 0;
      run_op(op, a, b, int'($urandom_range(0, 3)), fl, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
